// File: rtl/datapath_pipe.sv
// Single-issue instruction datapath: decodes one instruction per cycle, forwards the
// pending write-back into its operands, and stalls for a fixed-latency external ALU.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | ready for an instruction; register read addresses driven from instr
// ALU_WAIT | ALU busy; down-counter runs, result captured at terminal count 1
module datapath_pipe #(
  parameter int          DATA_W    = 32,
  parameter int          RADDR_W   = 6,
  parameter int          ALU_LAT   = 1,
  parameter logic [7:0]  OP_LIMM16 = 8'h02
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  input  logic [31:0]        instr,
  output logic               instr_ready,
  output logic [RADDR_W-1:0] ireg_r0,
  output logic [RADDR_W-1:0] ireg_r1,
  input  logic [DATA_W-1:0]  ireg_d0,
  input  logic [DATA_W-1:0]  ireg_d1,
  output logic [RADDR_W-1:0] ireg_rw,
  output logic [DATA_W-1:0]  ireg_dw,
  output logic               ireg_we,
  output logic [DATA_W-1:0]  alu_d0,
  output logic [DATA_W-1:0]  alu_d1,
  output logic [3:0]         alu_op,
  input  logic [DATA_W-1:0]  alu_dout,
  output logic               dbg_valid,
  output logic [DATA_W-1:0]  dbg_data,
  output logic               err
);

  localparam logic [7:0] OP_CP   = 8'hD2;
  localparam logic [7:0] OP_CPDR = 8'hD3;

  typedef enum logic {
    IDLE     = 1'b0,
    ALU_WAIT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           cnt_q;
  logic [RADDR_W-1:0]   alu_rd_q;

  logic [7:0]           op;
  logic [RADDR_W-1:0]   opd0, opd1, opd2;
  logic [15:0]          imm16;
  logic                 is_limm, is_cp, is_cpdr, is_alu;
  logic                 accept;
  logic [DATA_W-1:0]    src0, src1;

  assign op    = instr[31:24];
  assign opd0  = RADDR_W'(instr[23:18]);
  assign opd1  = RADDR_W'(instr[17:12]);
  assign opd2  = RADDR_W'(instr[11:6]);
  assign imm16 = instr[15:0];

  assign is_limm = (op == OP_LIMM16);
  assign is_cp   = (op == OP_CP);
  assign is_cpdr = (op == OP_CPDR);
  assign is_alu  = (op == 8'h10) || (op == 8'h11) || (op == 8'h12) || (op == 8'h14) ||
                   (op == 8'h15) || (op == 8'h18) || (op == 8'h19);

  // Ready is gated by rst_n so every output reads 0 while reset is held.
  assign instr_ready = rst_n && (state_q == IDLE);
  assign accept      = instr_valid && instr_ready;

  assign ireg_r0 = instr_ready ? opd1 : '0;
  assign ireg_r1 = instr_ready ? opd2 : '0;

  // The write pending this cycle has not reached the register file yet.
  assign src0 = (ireg_we && (ireg_rw == opd1)) ? ireg_dw : ireg_d0;
  assign src1 = (ireg_we && (ireg_rw == opd2)) ? ireg_dw : ireg_d1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept && is_alu) state_d = ALU_WAIT;
      ALU_WAIT: if (cnt_q == 3'd1)    state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      alu_rd_q  <= '0;
      ireg_we   <= 1'b0;
      ireg_rw   <= '0;
      ireg_dw   <= '0;
      alu_d0    <= '0;
      alu_d1    <= '0;
      alu_op    <= '0;
      dbg_valid <= 1'b0;
      dbg_data  <= '0;
      err       <= 1'b0;
    end else begin
      ireg_we   <= 1'b0;
      dbg_valid <= 1'b0;
      if (state_q == ALU_WAIT) begin
        cnt_q <= cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          ireg_we <= 1'b1;
          ireg_rw <= alu_rd_q;
          ireg_dw <= alu_dout;
        end
      end else if (accept) begin
        if (is_limm) begin
          ireg_we <= 1'b1;
          ireg_rw <= opd0;
          ireg_dw <= DATA_W'($signed(imm16));
        end else if (is_cp) begin
          ireg_we <= 1'b1;
          ireg_rw <= opd0;
          ireg_dw <= src0;
        end else if (is_cpdr) begin
          dbg_valid <= 1'b1;
          dbg_data  <= src0;
        end else if (is_alu) begin
          alu_d0   <= src0;
          alu_d1   <= src1;
          alu_op   <= op[3:0];
          alu_rd_q <= opd0;
          cnt_q    <= 3'(ALU_LAT);
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_datapath_pipe.sv
// Bench for datapath_pipe: directed scenarios then random traffic, checked every cycle
// against an in-order architectural model with a timed write-back queue.
module tb_datapath_pipe;
  localparam int         DATA_W  = 32;
  localparam int         RADDR_W = 6;
  localparam int         ALU_LAT = 3;
  localparam logic [7:0] OP_LIMM = 8'h02;
  localparam logic [7:0] OP_CP   = 8'hD2;
  localparam logic [7:0] OP_CPDR = 8'hD3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               instr_valid = 1'b0;
  logic [31:0]        instr = '0;
  logic               instr_ready;
  logic [RADDR_W-1:0] ireg_r0, ireg_r1, ireg_rw;
  logic [DATA_W-1:0]  ireg_d0, ireg_d1, ireg_dw;
  logic               ireg_we;
  logic [DATA_W-1:0]  alu_d0, alu_d1, alu_dout;
  logic [3:0]         alu_op;
  logic               dbg_valid;
  logic [DATA_W-1:0]  dbg_data;
  logic               err;

  datapath_pipe #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .ALU_LAT(ALU_LAT), .OP_LIMM16(OP_LIMM)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .ireg_r0(ireg_r0), .ireg_r1(ireg_r1), .ireg_d0(ireg_d0), .ireg_d1(ireg_d1),
    .ireg_rw(ireg_rw), .ireg_dw(ireg_dw), .ireg_we(ireg_we),
    .alu_d0(alu_d0), .alu_d1(alu_d1), .alu_op(alu_op), .alu_dout(alu_dout),
    .dbg_valid(dbg_valid), .dbg_data(dbg_data), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] alu_f(input logic [3:0] f, input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    case (f)
      4'h0:    return a & b;
      4'h1:    return a | b;
      4'h2:    return a ^ b;
      4'h4:    return a + b;
      4'h5:    return a - b;
      4'h8:    return a << b[4:0];
      4'h9:    return a >> b[4:0];
      default: return '0;
    endcase
  endfunction

  // Environment: register file with combinational read, and the external ALU.
  logic [DATA_W-1:0] rf [64];
  assign ireg_d0  = rf[ireg_r0];
  assign ireg_d1  = rf[ireg_r1];
  assign alu_dout = alu_f(alu_op, alu_d0, alu_d1);

  typedef struct {
    int                 cyc;
    logic [RADDR_W-1:0] rw;
    logic [DATA_W-1:0]  dw;
    logic               is_alu;
    logic [3:0]         aop;
  } wb_t;

  logic [DATA_W-1:0]  ref_rf [64];
  wb_t                wq[$];
  int                 cyc = 0;
  int                 ready_cyc = 0;
  int                 dbg_cyc = -1;
  logic [DATA_W-1:0]  dbg_val = '0;
  logic               m_err = 1'b0;
  logic [RADDR_W-1:0] last_rw = '0;
  logic [DATA_W-1:0]  last_dw = '0;
  int                 checks = 0;
  int                 errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mk3(input logic [7:0] op, input logic [5:0] d,
                                      input logic [5:0] s0, input logic [5:0] s1);
    return {op, d, s0, s1, 6'd0};
  endfunction

  function automatic logic [31:0] mki(input logic [7:0] op, input logic [5:0] d, input logic [15:0] imm);
    return {op, d, 2'b00, imm};
  endfunction

  function automatic logic is_alu_op(input logic [7:0] op);
    return op inside {8'h10, 8'h11, 8'h12, 8'h14, 8'h15, 8'h18, 8'h19};
  endfunction

  // Architectural effect of an accepted instruction, scheduled by its visible cycle.
  task automatic model_accept(input logic [31:0] ins);
    logic [7:0]         op;
    logic [RADDR_W-1:0] d, s0, s1;
    logic [15:0]        imm;
    wb_t                e;
    op = ins[31:24]; d = ins[23:18]; s0 = ins[17:12]; s1 = ins[11:6]; imm = ins[15:0];
    e.rw = d; e.is_alu = 1'b0; e.aop = op[3:0]; e.cyc = cyc + 1; e.dw = '0;
    if (op == OP_LIMM) begin
      e.dw = {{(DATA_W-16){imm[15]}}, imm};
      wq.push_back(e);
    end else if (op == OP_CP) begin
      e.dw = ref_rf[s0];
      wq.push_back(e);
    end else if (op == OP_CPDR) begin
      dbg_cyc = cyc + 1;
      dbg_val = ref_rf[s0];
    end else if (is_alu_op(op)) begin
      e.dw     = alu_f(op[3:0], ref_rf[s0], ref_rf[s1]);
      e.is_alu = 1'b1;
      e.cyc    = cyc + ALU_LAT + 1;
      ready_cyc = cyc + ALU_LAT + 1;
      wq.push_back(e);
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic step(input logic v, input logic [31:0] ins);
    logic               exp_we, obs_we;
    logic [RADDR_W-1:0] obs_rw;
    logic [DATA_W-1:0]  obs_dw;
    instr_valid = v;
    instr       = ins;
    @(negedge clk);
    while (wq.size() > 0 && wq[0].cyc < cyc) void'(wq.pop_front());
    exp_we = (wq.size() > 0) && (wq[0].cyc == cyc);
    chk("ireg_we", 64'(ireg_we), 64'(exp_we));
    if (exp_we) begin
      last_rw = wq[0].rw;
      last_dw = wq[0].dw;
      ref_rf[last_rw] = last_dw;
      if (wq[0].is_alu) chk("alu_op", 64'(alu_op), 64'(wq[0].aop));
      void'(wq.pop_front());
    end
    chk("ireg_rw", 64'(ireg_rw), 64'(last_rw));
    chk("ireg_dw", 64'(ireg_dw), 64'(last_dw));
    chk("dbg_valid", 64'(dbg_valid), 64'(cyc == dbg_cyc));
    if (cyc == dbg_cyc) chk("dbg_data", 64'(dbg_data), 64'(dbg_val));
    chk("instr_ready", 64'(instr_ready), 64'(cyc >= ready_cyc));
    chk("err", 64'(err), 64'(m_err));
    if (v && cyc >= ready_cyc) model_accept(ins);
    obs_we = ireg_we; obs_rw = ireg_rw; obs_dw = ireg_dw;
    @(posedge clk);
    cyc++;
    #1;
    if (obs_we) rf[obs_rw] = obs_dw;
  endtask

  task automatic reset_dut(input int n);
    rst_n       = 1'b0;
    instr_valid = 1'b1;
    instr       = 32'h02FF_FFFF;
    repeat (n) begin
      @(negedge clk);
      chk("rst_ready", 64'(instr_ready), 64'd0);
      chk("rst_we", 64'(ireg_we), 64'd0);
      chk("rst_rw_dw", 64'({ireg_rw, ireg_dw}), 64'd0);
      chk("rst_raddr", 64'({ireg_r0, ireg_r1}), 64'd0);
      chk("rst_alu", 64'({alu_d0, alu_d1, alu_op}), 64'd0);
      chk("rst_dbg_err", 64'({dbg_valid, dbg_data, err}), 64'd0);
      @(posedge clk);
      cyc++;
      #1;
    end
    wq.delete();
    ready_cyc = 0; dbg_cyc = -1; m_err = 1'b0; last_rw = '0; last_dw = '0;
    instr_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] alu_ops [7];
    logic [7:0] op;
    int         r;
    alu_ops = '{8'h10, 8'h11, 8'h12, 8'h14, 8'h15, 8'h18, 8'h19};
    for (int i = 0; i < 64; i++) begin
      rf[i]     = $urandom;
      ref_rf[i] = rf[i];
    end
    reset_dut(3);

    // Sign-extended immediate load.
    step(1'b1, mki(OP_LIMM, 6'd5, 16'h8001));
    step(1'b0, '0);
    // r1=7, r2=9, then ADD r6 = r1 + r2 while further loads are held off by the stall.
    step(1'b1, mki(OP_LIMM, 6'd1, 16'd7));
    step(1'b1, mki(OP_LIMM, 6'd2, 16'd9));
    step(1'b1, mk3(8'h14, 6'd6, 6'd1, 6'd2));
    for (int i = 0; i < 5; i++) step(1'b1, mki(OP_LIMM, 6'd7, 16'(i + 1)));
    step(1'b0, '0);
    // Copy immediately after a load relies on forwarding.
    step(1'b1, mki(OP_LIMM, 6'd3, 16'd10));
    step(1'b1, mk3(OP_CP, 6'd4, 6'd3, 6'd0));
    step(1'b0, '0);
    step(1'b0, '0);
    rf[2] = 32'h0000_DEAD;
    ref_rf[2] = 32'h0000_DEAD;
    step(1'b1, mk3(OP_CPDR, 6'd0, 6'd2, 6'd0));
    step(1'b0, '0);
    // Illegal opcode is sticky; later loads still write.
    step(1'b1, mk3(8'hFF, 6'd0, 6'd0, 6'd0));
    step(1'b1, mki(OP_LIMM, 6'd8, 16'h1234));
    step(1'b0, '0);
    step(1'b0, '0);
    // Reset in the middle of an ALU wait abandons the write.
    step(1'b1, mk3(8'h14, 6'd9, 6'd1, 6'd2));
    step(1'b0, '0);
    reset_dut(2);
    step(1'b1, mki(OP_LIMM, 6'd10, 16'h0042));
    step(1'b0, '0);
    step(1'b0, '0);

    for (int n = 0; n < 1500; n++) begin
      if (n == 750) reset_dut(2);
      r = $urandom_range(0, 19);
      if (r < 5)       op = OP_LIMM;
      else if (r < 8)  op = OP_CP;
      else if (r < 10) op = OP_CPDR;
      else if (r < 19) op = alu_ops[$urandom_range(0, 6)];
      else             op = 8'h13;
      if (op == OP_LIMM)
        step(($urandom_range(0, 3) != 0), mki(op, 6'($urandom_range(0, 7)), 16'($urandom)));
      else
        step(($urandom_range(0, 3) != 0), {op, 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
                                           6'($urandom_range(0, 7)), 6'($urandom)});
    end
    for (int i = 0; i < ALU_LAT + 2; i++) step(1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
